// File: rtl/universal_shift_register.sv
// rtl/universal_shift_register.sv - mode-selected shift register with handshaked full-duplex frame serdes
module universal_shift_register #(
  parameter int                 WIDTH     = 8,
  parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] pdata,
  input  logic             si,
  input  logic             start,
  input  logic             msb_first,
  output logic [WIDTH-1:0] q,
  output logic             so,
  output logic             so_valid,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_SHR  = 3'b001;
  localparam logic [2:0] MODE_SHL  = 3'b010;
  localparam logic [2:0] MODE_ROR  = 3'b011;
  localparam logic [2:0] MODE_ROL  = 3'b100;
  localparam logic [2:0] MODE_LOAD = 3'b101;
  localparam logic [2:0] MODE_ASR  = 3'b110;

  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             dir_q, dir_d;
  logic [WIDTH-1:0] q_d;
  logic             so_d, so_valid_d, busy_d, done_d;

  // State register: every output is a flop, so there is no input-to-output path
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      dir_q    <= 1'b1;
      q        <= RESET_VAL;
      so       <= 1'b0;
      so_valid <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dir_q    <= dir_d;
      q        <= q_d;
      so       <= so_d;
      so_valid <= so_valid_d;
      busy     <= busy_d;
      done     <= done_d;
    end
  end

  // Next state: start beats mode in IDLE; a frame ignores mode/start and runs WIDTH shifts
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dir_d      = dir_q;
    q_d        = q;
    so_d       = so;
    so_valid_d = 1'b0;
    busy_d     = busy;
    done_d     = 1'b0;
    if (en) begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            q_d     = pdata;
            cnt_d   = '0;
            dir_d   = msb_first;
            busy_d  = 1'b1;
            state_d = SHIFT;
          end else begin
            case (mode)
              MODE_SHR: begin
                q_d  = {si, q[WIDTH-1:1]};
                so_d = q[0];
              end
              MODE_SHL: begin
                q_d  = {q[WIDTH-2:0], si};
                so_d = q[WIDTH-1];
              end
              MODE_ROR: begin
                q_d  = {q[0], q[WIDTH-1:1]};
                so_d = q[0];
              end
              MODE_ROL: begin
                q_d  = {q[WIDTH-2:0], q[WIDTH-1]};
                so_d = q[WIDTH-1];
              end
              MODE_LOAD: q_d = pdata;
              MODE_ASR: begin
                q_d  = {q[WIDTH-1], q[WIDTH-1:1]};
                so_d = q[0];
              end
              MODE_HOLD: q_d = q;
              default:   q_d = q;
            endcase
          end
        end
        SHIFT: begin
          if (dir_q) begin
            so_d = q[WIDTH-1];
            q_d  = {q[WIDTH-2:0], si};
          end else begin
            so_d = q[0];
            q_d  = {si, q[WIDTH-1:1]};
          end
          so_valid_d = 1'b1;
          if (cnt_q == LAST_BIT) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_universal_shift_register.sv
// tb/tb_universal_shift_register.sv - scoreboard bench for universal_shift_register
module tb_universal_shift_register;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [2:0] mode;
  logic [7:0] pdata;
  logic       si;
  logic       start;
  logic       msb_first;
  logic [7:0] q;
  logic       so;
  logic       so_valid;
  logic       busy;
  logic       done;

  int n_cmp = 0;
  int n_err = 0;

  logic       sb_so[$];
  logic [7:0] sb_q[$];

  universal_shift_register #(.WIDTH(8), .RESET_VAL(8'h00)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .mode      (mode),
    .pdata     (pdata),
    .si        (si),
    .start     (start),
    .msb_first (msb_first),
    .q         (q),
    .so        (so),
    .so_valid  (so_valid),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Monitor: pop one expected serial bit per so_valid, and the expected word on done
  always @(negedge clk) begin
    if (rst_n && so_valid) begin
      if (sb_so.size() == 0) check("sb_so_underflow", 1, 0);
      else check("so_bit", so, sb_so.pop_front());
    end
    if (rst_n && done) begin
      check("done_with_valid", so_valid, 1);
      if (sb_q.size() == 0) check("sb_q_underflow", 1, 0);
      else check("frame_q", q, sb_q.pop_front());
    end
  end

  task automatic idle_op(input string tag, input logic e, input logic [2:0] m, input logic s,
                         input logic [7:0] pd, input logic [7:0] exp_q, input logic exp_so);
    en = e; mode = m; si = s; pdata = pd; start = 1'b0;
    @(posedge clk); #1;
    check({tag, "_q"}, q, exp_q);
    check({tag, "_so"}, so, exp_so);
    check({tag, "_so_valid"}, so_valid, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  task automatic run_frame(input string tag, input logic [7:0] tx, input logic [7:0] rx,
                           input logic dir, input logic [2:0] start_mode,
                           input int stall_at, input bit disturb);
    logic [7:0] fq;
    logic       fso;
    for (int k = 0; k < 8; k++) sb_so.push_back(dir ? tx[7-k] : tx[k]);
    sb_q.push_back(rx);
    pdata = tx; msb_first = dir; start = 1'b1; en = 1'b1; mode = start_mode;
    @(posedge clk); #1;
    start = 1'b0; mode = 3'b000;
    check({tag, "_start_busy"}, busy, 1);
    check({tag, "_start_q"}, q, tx);
    check({tag, "_start_valid"}, so_valid, 0);
    for (int k = 0; k < 8; k++) begin
      si = dir ? rx[7-k] : rx[k];
      if (disturb && k == 2) begin start = 1'b1; mode = 3'b101; pdata = 8'hFF; msb_first = ~dir; end
      if (disturb && k == 3) begin start = 1'b0; mode = 3'b011; end
      @(posedge clk); #1;
      check({tag, "_done"}, done, (k == 7));
      check({tag, "_busy"}, busy, (k != 7));
      check({tag, "_valid"}, so_valid, 1);
      if (k == stall_at - 1) begin
        fq = q; fso = so; en = 1'b0;
        repeat (3) begin
          @(posedge clk); #1;
          check({tag, "_stall_valid"}, so_valid, 0);
          check({tag, "_stall_q"}, q, fq);
          check({tag, "_stall_so"}, so, fso);
          check({tag, "_stall_busy"}, busy, 1);
        end
        en = 1'b1;
      end
    end
    start = 1'b0; mode = 3'b000;
    check({tag, "_end_q"}, q, rx);
    @(posedge clk); #1;
    check({tag, "_post_done"}, done, 0);
    check({tag, "_post_busy"}, busy, 0);
    check({tag, "_post_q"}, q, rx);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; en = 1'b0; mode = 3'b000; pdata = 8'h00; si = 1'b0; start = 1'b0; msb_first = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_q", q, 8'h00);
    check("rst_so", so, 0);
    check("rst_valid", so_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    rst_n = 1'b1;

    idle_op("load81", 1, 3'b101, 0, 8'h81, 8'h81, 0);
    idle_op("rol",    1, 3'b100, 0, 8'h00, 8'h03, 1);
    idle_op("asr1",   1, 3'b110, 0, 8'h00, 8'h01, 1);
    idle_op("load80", 1, 3'b101, 0, 8'h80, 8'h80, 1);
    idle_op("asr2",   1, 3'b110, 0, 8'h00, 8'hC0, 0);
    idle_op("shl",    1, 3'b010, 1, 8'h00, 8'h81, 1);
    idle_op("rsvd",   1, 3'b111, 0, 8'h00, 8'h81, 1);
    idle_op("shr",    1, 3'b001, 0, 8'h00, 8'h40, 1);
    idle_op("ror",    1, 3'b011, 0, 8'h00, 8'h20, 0);
    idle_op("hold",   1, 3'b000, 1, 8'hFF, 8'h20, 0);
    idle_op("en_low", 0, 3'b100, 1, 8'hFF, 8'h20, 0);

    run_frame("msb",      8'hA5, 8'h3C, 1'b1, 3'b000, -1, 0);
    run_frame("lsb",      8'h01, 8'h00, 1'b0, 3'b000, -1, 0);
    run_frame("stall",    8'hA5, 8'h3C, 1'b1, 3'b000,  4, 0);
    run_frame("prio",     8'h5A, 8'hC3, 1'b1, 3'b101, -1, 0);
    run_frame("disturb",  8'h96, 8'h6B, 1'b0, 3'b000, -1, 1);

    for (int k = 0; k < 8; k++) sb_so.push_back(k == 0 || k == 2 || k == 5 || k == 7);
    sb_q.push_back(8'h3C);
    pdata = 8'hA5; msb_first = 1'b1; start = 1'b1; en = 1'b1; mode = 3'b000;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      si = (k == 2);
      @(posedge clk); #1;
    end
    check("pre_rst_valid", so_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_q", q, 8'h00);
    check("midrst_busy", busy, 0);
    check("midrst_so", so, 0);
    check("midrst_valid", so_valid, 0);
    check("midrst_done", done, 0);
    sb_so.delete();
    sb_q.delete();
    #1 rst_n = 1'b1;

    run_frame("after_rst", 8'hC7, 8'h2E, 1'b1, 3'b000, -1, 0);

    check("sb_so_empty", sb_so.size(), 0);
    check("sb_q_empty", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
